// File: rtl/uart_rx_os16_if.sv
// uart_rx_os16_if
//   Line-side and byte-side signals of the oversampled UART receiver.
//   rx_in      : raw RX pin (async, idle high)
//   data_out   : last correctly framed byte
//   data_valid : one-cycle strobe, data_out just updated
//   frame_err  : one-cycle strobe, stop bit sampled low
//   busy       : receiver is not idle
//   slave modport  -> the receiver; master modport -> line driver / byte consumer.
interface uart_rx_os16_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport slave  (input  rx_in, output data_out, data_valid, frame_err, busy);
  modport master (output rx_in, input  data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx_os16.sv
// uart_rx_os16
//   16x-oversampled 8N1 UART receiver, LSB first. The RX pin is synchronised
//   by two flops, a divider produces one oversample tick every CLK_DIV clocks,
//   and each bit is sampled at its midpoint. False starts (line high again at
//   mid start bit) are dropped silently; a low stop bit raises frame_err and the
//   receiver then waits for the line to go high before re-arming.
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-high reset
//     rx_if  : slave modport (rx_in in; data_out, data_valid, frame_err, busy out)
module uart_rx_os16 #(
  parameter int unsigned CLK_DIV = 6   // clk cycles per oversample tick, 2..255
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_os16_if.slave  rx_if
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_e;

  state_e     state_q, state_d;
  logic       rx_m_q, rx_s_q;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [3:0] sub_cnt_q, sub_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       tick;

  // Divider is held at 0 while idle, so tick can never fire there.
  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    if (state_q == IDLE || state_q == WAIT_HIGH || tick)
      div_cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      div_cnt_q <= 8'd0;
      sub_cnt_q <= 4'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      rx_m_q    <= rx_if.rx_in;
      rx_s_q    <= rx_m_q;
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      sub_cnt_q <= sub_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sub_cnt_d = sub_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d   = START;
          sub_cnt_d = 4'd0;
        end
      end

      // Eight ticks in: middle of the start bit.
      START: begin
        if (tick) begin
          sub_cnt_d = sub_cnt_q + 4'd1;
          if (sub_cnt_q == 4'd7) begin
            if (rx_s_q) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              sub_cnt_d = 4'd0;
              bit_idx_d = 3'd0;
            end
          end
        end
      end

      // Sixteen ticks per bit; sub_cnt wraps naturally from 15 to 0.
      DATA: begin
        if (tick) begin
          sub_cnt_d = sub_cnt_q + 4'd1;
          if (sub_cnt_q == 4'd15) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_d = STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      // Leaving at mid stop bit leaves half a bit to catch the next start edge.
      STOP: begin
        if (tick) begin
          sub_cnt_d = sub_cnt_q + 4'd1;
          if (sub_cnt_q == 4'd15) begin
            if (rx_s_q) begin
              data_d  = shift_q;
              dv_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end
      end

      // A held-low line (break) must not look like an endless stream of starts.
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.busy       = (state_q != IDLE);

endmodule

// File: doc/uart_rx_os16.md
Name: uart_rx_os16

Overview:
- 16x-oversampled UART receiver (8N1, LSB first). Replaces the un-oversampled receive path in front of the echo transmitter.
- Synchronises the asynchronous RX pin and samples each bit at mid-bit.
- Rejects false starts and detects framing errors.
- Delivers each byte with a one-cycle strobe that is directly compatible with the transmitter's write_enable input.

Parameters:
- CLK_DIV, 6: clk cycles per oversample tick (bit period = 16*CLK_DIV clks); legal range 2..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_in  input  1  raw UART RX line (async, idle high)
- data_out  output  8  last correctly framed byte
- data_valid  output  1  one-cycle strobe: data_out just updated
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high) values:
  - data_out=8'h00; data_valid=0; frame_err=0; busy=0.
  - Both sync flops = 1; state=IDLE; counters = 0.
  - Reset mid-frame aborts the frame immediately; no strobe is produced.
- Synchroniser: 2-flop chain; rx_s is the second flop output. A rx_in edge reaches rx_s after 2 clk edges.
- Tick divider:
  - div_cnt counts 0..CLK_DIV-1; tick = (div_cnt==CLK_DIV-1); wraps to 0 after the tick.
  - Held at 0 in IDLE and WAIT_HIGH. Starts counting on the cycle after leaving IDLE.
- sub_cnt (4 bits) counts ticks within a bit; bit_idx (3 bits) counts data bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START; sub_cnt=0.
  - START: on each tick, sub_cnt++. On the tick where sub_cnt==7 (mid start bit):
    - rx_s==1 -> IDLE (false start, no strobe).
    - otherwise -> DATA; sub_cnt=0; bit_idx=0.
  - DATA: on each tick, sub_cnt++. On the tick where sub_cnt==15 (one full bit later = mid data bit):
    - shift_reg <= {rx_s, shift_reg[7:1]}.
    - bit_idx==7 -> STOP; else bit_idx++.
    - sub_cnt wraps to 0.
  - STOP: on the tick where sub_cnt==15:
    - rx_s==1 -> data_out <= {rx_s_sample_chain} i.e. the completed shift_reg; data_valid=1 for the next cycle only; -> IDLE.
    - rx_s==0 -> frame_err=1 for one cycle; data_out unchanged; -> WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then -> IDLE. This prevents a break condition (line held low) from retriggering continuously.
- Strobes: data_valid and frame_err are registered. Each is high for exactly 1 clk and never high together. Both are 0 in all other cycles.
- Back-to-back frames: STOP returns to IDLE on the mid-stop-bit tick. A start edge arriving half a bit later is caught, so continuous streaming with a single stop bit is supported.
- Latency: rx_in falling edge of the start bit -> data_valid high = 2 (sync) + 1 (IDLE exit) + (8+16*8+16)*CLK_DIV clk edges, ±1 cycle.
- busy is combinational from state: (state != IDLE).
- No flow control. The consumer must accept data_valid in the cycle it is asserted. data_out holds its value until the next good frame.

Test Plan:
- CLK_DIV=4 (64 clk/bit): send 0x55 then 0xA3 back-to-back, 1 stop bit each.
  -> Two data_valid pulses, data_out=0x55 then 0xA3. No frame_err. busy drops between frames only during the half-stop-bit gap.
- Glitch: rx_in low for 10 clks, then high.
  -> FSM returns to IDLE at the mid-start sample. No data_valid, no frame_err; data_out keeps its previous value.
- Framing error: send 0x3C with the stop bit driven low, then hold the line low for 5 bit times, then release high.
  -> Exactly one frame_err pulse; data_out unchanged; busy stays high until rx_s goes high. Then the next good frame 0x31 yields data_valid with data_out=0x31.
- Reset mid-frame: assert reset during bit 4 of 0xFF, release, then send 0x0F.
  -> Outputs return to reset values immediately; no strobe for the aborted frame; 0x0F received correctly.
- Baud tolerance: CLK_DIV=6; transmit 0x96 with the bit period stretched +3% and then -3%.
  -> data_out=0x96 both times.
- Latency check: CLK_DIV=4, single 0x00 frame.
  -> data_valid asserted 2+1+(8+128+16)*4 = 611 clks (±1) after the start-bit falling edge.
